// File: rtl/updown_count_monitor_if.sv
// Bundle of the upstream count/clear inputs and the monitor's tracking outputs.
// The monitor takes the slave side; whatever drives q_in and clr takes the master side.
interface updown_count_monitor_if #(
  parameter int LAP_W = 8
);
  logic [1:0]       q_in;
  logic             clr;
  logic             valid;
  logic             dir;
  logic             step;
  logic             wrap_up;
  logic             wrap_dn;
  logic [LAP_W-1:0] laps;
  logic             err;

  modport master (
    output q_in, clr,
    input  valid, dir, step, wrap_up, wrap_dn, laps, err
  );

  modport slave (
    input  q_in, clr,
    output valid, dir, step, wrap_up, wrap_dn, laps, err
  );
endinterface

// File: rtl/updown_count_monitor.sv
// Watches a 2-bit up/down counter, pulses per legal step, keeps a saturating signed
// lap count and latches a sticky fault when the counter jumps by two.
module updown_count_monitor #(
  parameter int LAP_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  updown_count_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [LAP_W-1:0] LAPS_MAX = {1'b0, {(LAP_W-1){1'b1}}};
  localparam logic [LAP_W-1:0] LAPS_MIN = {1'b1, {(LAP_W-1){1'b0}}};
  localparam logic [LAP_W-1:0] LAPS_ONE = {{(LAP_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [1:0]       q_prev_q;
  logic [1:0]       rst_sync_q;
  logic             valid_q, valid_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             wrap_up_q, wrap_up_d;
  logic             wrap_dn_q, wrap_dn_d;
  logic [LAP_W-1:0] laps_q, laps_d;
  logic             err_q, err_d;
  logic [1:0]       delta;

  // rst_sync_q[1] only rises two edges after reset release, so INIT is never left on the release edge itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
      state_q    <= INIT;
      q_prev_q   <= 2'd0;
      valid_q    <= 1'b0;
      dir_q      <= 1'b0;
      step_q     <= 1'b0;
      wrap_up_q  <= 1'b0;
      wrap_dn_q  <= 1'b0;
      laps_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
      state_q    <= state_d;
      q_prev_q   <= bus.q_in;
      valid_q    <= valid_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      wrap_up_q  <= wrap_up_d;
      wrap_dn_q  <= wrap_dn_d;
      laps_q     <= laps_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    step_d    = 1'b0;
    wrap_up_d = 1'b0;
    wrap_dn_d = 1'b0;
    laps_d    = laps_q;
    err_d     = err_q;
    delta     = bus.q_in - q_prev_q;

    if (bus.clr) begin
      state_d = INIT;
      laps_d  = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (rst_sync_q[1]) begin
            state_d = TRACK;
          end
        end
        TRACK: begin
          case (delta)
            2'd1: begin
              step_d = 1'b1;
              dir_d  = 1'b1;
              if (q_prev_q == 2'd3) begin
                wrap_up_d = 1'b1;
                if (laps_q != LAPS_MAX) begin
                  laps_d = laps_q + LAPS_ONE;
                end
              end
            end
            2'd3: begin
              step_d = 1'b1;
              dir_d  = 1'b0;
              if (q_prev_q == 2'd0) begin
                wrap_dn_d = 1'b1;
                if (laps_q != LAPS_MIN) begin
                  laps_d = laps_q - LAPS_ONE;
                end
              end
            end
            2'd2: begin
              state_d = FAULT;
              err_d   = 1'b1;
            end
            default: ;
          endcase
        end
        FAULT: begin
          err_d = 1'b1;
        end
        default: begin
          state_d = INIT;
        end
      endcase
    end

    valid_d = (state_d == TRACK);
  end

  assign bus.valid   = valid_q;
  assign bus.dir     = dir_q;
  assign bus.step    = step_q;
  assign bus.wrap_up = wrap_up_q;
  assign bus.wrap_dn = wrap_dn_q;
  assign bus.laps    = laps_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_updown_count_monitor.sv
// Directed bench for updown_count_monitor with hand-computed expectations per scenario.
module tb_updown_count_monitor;

  localparam int LAP_W = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  updown_count_monitor_if #(.LAP_W(LAP_W)) bus ();

  updown_count_monitor #(.LAP_W(LAP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] q);
    bus.q_in = q;
    tick();
  endtask

  // Reset with q_in held at q0, release on a falling edge, then wait (bounded) for TRACK.
  task automatic apply_reset(input logic [1:0] q0);
    bit seen;
    reset    = 1'b0;
    bus.clr  = 1'b0;
    bus.q_in = q0;
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_to_track: valid=%b required 1 within 8 cycles", bus.valid);
    end
  endtask

  task automatic test_reset();
    logic [LAP_W+5:0] obs;
    reset    = 1'b1;
    bus.clr  = 1'b0;
    bus.q_in = 2'd0;
    #3;
    reset = 1'b0;
    #1;
    obs = {bus.valid, bus.dir, bus.step, bus.wrap_up, bus.wrap_dn, bus.err, bus.laps};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: outputs=%h required 0", obs);
    end
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_sync_hold: valid=%b required 0 two edges after release", bus.valid);
    end
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.step !== 1'b0) begin
      errors++;
      $display("FAIL reset_sync_track: valid=%b step=%b required valid=1 step=0", bus.valid, bus.step);
    end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_count_up();
    logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic       wu  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] lp  [5] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
    apply_reset(2'd0);
    for (int i = 0; i < 5; i++) begin
      drive(seq[i]);
      checks++;
      if (bus.step !== 1'b1 || bus.dir !== 1'b1 || bus.wrap_up !== wu[i] ||
          bus.wrap_dn !== 1'b0 || bus.laps !== lp[i]) begin
        errors++;
        $display("FAIL count_up[%0d]: step=%b dir=%b wu=%b wd=%b laps=%h required 1 1 %b 0 %h",
                 i, bus.step, bus.dir, bus.wrap_up, bus.wrap_dn, bus.laps, wu[i], lp[i]);
      end
    end
    drive(2'd1);
    checks++;
    if (bus.step !== 1'b0 || bus.dir !== 1'b1 || bus.laps !== 8'd1) begin
      errors++;
      $display("FAIL count_up_hold: step=%b dir=%b laps=%h required 0 1 01", bus.step, bus.dir, bus.laps);
    end
    $display("test_count_up done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_count_down();
    logic [1:0] seq [6] = '{2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
    logic       wd  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] lp  [6] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE};
    int         nwd;
    apply_reset(2'd1);
    nwd = 0;
    for (int i = 0; i < 6; i++) begin
      drive(seq[i]);
      if (bus.wrap_dn === 1'b1) nwd++;
      checks++;
      if (bus.step !== 1'b1 || bus.dir !== 1'b0 || bus.wrap_dn !== wd[i] ||
          bus.wrap_up !== 1'b0 || bus.laps !== lp[i]) begin
        errors++;
        $display("FAIL count_down[%0d]: step=%b dir=%b wd=%b wu=%b laps=%h required 1 0 %b 0 %h",
                 i, bus.step, bus.dir, bus.wrap_dn, bus.wrap_up, bus.laps, wd[i], lp[i]);
      end
    end
    checks++;
    if (nwd != 2) begin
      errors++;
      $display("FAIL count_down_wraps: wrap_dn pulses=%0d required 2", nwd);
    end
    $display("test_count_down done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_fault();
    logic [1:0] after [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    apply_reset(2'd0);
    drive(2'd1); drive(2'd2); drive(2'd3); drive(2'd0); drive(2'd1);
    checks++;
    if (bus.laps !== 8'd1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL fault_setup: laps=%h err=%b required 01 0", bus.laps, bus.err);
    end
    drive(2'd3);
    checks++;
    if (bus.err !== 1'b1 || bus.valid !== 1'b0 || bus.step !== 1'b0 || bus.wrap_up !== 1'b0 ||
        bus.wrap_dn !== 1'b0 || bus.dir !== 1'b1) begin
      errors++;
      $display("FAIL fault_entry: err=%b valid=%b step=%b wu=%b wd=%b dir=%b required 1 0 0 0 0 1",
               bus.err, bus.valid, bus.step, bus.wrap_up, bus.wrap_dn, bus.dir);
    end
    for (int i = 0; i < 5; i++) begin
      drive(after[i]);
      checks++;
      if (bus.err !== 1'b1 || bus.valid !== 1'b0 || bus.step !== 1'b0 || bus.wrap_up !== 1'b0 ||
          bus.laps !== 8'd1) begin
        errors++;
        $display("FAIL fault_frozen[%0d]: err=%b valid=%b step=%b wu=%b laps=%h required 1 0 0 0 01",
                 i, bus.err, bus.valid, bus.step, bus.wrap_up, bus.laps);
      end
    end
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    checks++;
    if (bus.err !== 1'b0 || bus.laps !== 8'd0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL fault_clr: err=%b laps=%h valid=%b required 0 00 0", bus.err, bus.laps, bus.valid);
    end
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.step !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL fault_retrack: valid=%b step=%b err=%b required 1 0 0", bus.valid, bus.step, bus.err);
    end
    $display("test_fault done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_saturation();
    int exp_laps;
    apply_reset(2'd0);
    for (int lap = 1; lap <= 130; lap++) begin
      drive(2'd1); drive(2'd2); drive(2'd3); drive(2'd0);
      exp_laps = (lap < 127) ? lap : 127;
      checks++;
      if (bus.wrap_up !== 1'b1 || bus.laps !== 8'(exp_laps)) begin
        errors++;
        $display("FAIL sat_up[%0d]: wu=%b laps=%h required 1 %h", lap, bus.wrap_up, bus.laps, 8'(exp_laps));
      end
    end
    drive(2'd3);
    checks++;
    if (bus.wrap_dn !== 1'b1 || bus.laps !== 8'd126) begin
      errors++;
      $display("FAIL sat_down1: wd=%b laps=%h required 1 7e", bus.wrap_dn, bus.laps);
    end
    drive(2'd2); drive(2'd1); drive(2'd0); drive(2'd3);
    checks++;
    if (bus.wrap_dn !== 1'b1 || bus.laps !== 8'd125) begin
      errors++;
      $display("FAIL sat_down2: wd=%b laps=%h required 1 7d", bus.wrap_dn, bus.laps);
    end
    $display("test_saturation done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_clr_wrap();
    apply_reset(2'd0);
    drive(2'd1); drive(2'd2); drive(2'd3); drive(2'd0);
    drive(2'd1); drive(2'd2); drive(2'd3);
    checks++;
    if (bus.laps !== 8'd1) begin
      errors++;
      $display("FAIL clr_wrap_setup: laps=%h required 01", bus.laps);
    end
    bus.clr = 1'b1;
    drive(2'd0);
    bus.clr = 1'b0;
    checks++;
    if (bus.wrap_up !== 1'b0 || bus.step !== 1'b0 || bus.laps !== 8'd0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_wrap: wu=%b step=%b laps=%h valid=%b required 0 0 00 0",
               bus.wrap_up, bus.step, bus.laps, bus.valid);
    end
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.step !== 1'b0 || bus.laps !== 8'd0) begin
      errors++;
      $display("FAIL clr_wrap_after: valid=%b step=%b laps=%h required 1 0 00", bus.valid, bus.step, bus.laps);
    end
    $display("test_clr_wrap done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_async_reset();
    logic [LAP_W+5:0] obs;
    apply_reset(2'd0);
    drive(2'd1); drive(2'd2); drive(2'd3); drive(2'd0); drive(2'd1);
    #2;
    reset    = 1'b0;
    bus.q_in = 2'd2;
    #1;
    obs = {bus.valid, bus.dir, bus.step, bus.wrap_up, bus.wrap_dn, bus.err, bus.laps};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL async_reset_track: outputs=%h required 0", obs);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.step !== 1'b0 || bus.valid !== 1'b0 || bus.wrap_up !== 1'b0 || bus.wrap_dn !== 1'b0) begin
        errors++;
        $display("FAIL async_init[%0d]: step=%b valid=%b wu=%b wd=%b required 0 0 0 0",
                 i, bus.step, bus.valid, bus.wrap_up, bus.wrap_dn);
      end
    end
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.step !== 1'b0) begin
      errors++;
      $display("FAIL async_retrack: valid=%b step=%b required 1 0", bus.valid, bus.step);
    end
    drive(2'd3);
    checks++;
    if (bus.step !== 1'b1 || bus.dir !== 1'b1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL async_first_step: step=%b dir=%b err=%b required 1 1 0", bus.step, bus.dir, bus.err);
    end
    drive(2'd1);
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL async_fault_setup: err=%b required 1", bus.err);
    end
    #3;
    reset = 1'b0;
    #1;
    obs = {bus.valid, bus.dir, bus.step, bus.wrap_up, bus.wrap_dn, bus.err, bus.laps};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL async_reset_fault: outputs=%h required 0", obs);
    end
    apply_reset(2'd1);
    $display("test_async_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    bus.clr  = 1'b0;
    bus.q_in = 2'd0;
    test_reset();
    test_count_up();
    test_count_down();
    test_fault();
    test_saturation();
    test_clr_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_count_monitor.md
UPDOWN_COUNT_MONITOR -- requirements
Module: updown_count_monitor

Interface
REQ-001 The block SHALL have parameter LAP_W, default 8, giving the width of the signed lap counter (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port q_in, input, 2 bits: count value from the upstream 2-bit up/down counter, synchronous to clk.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous clear of lap count and fault.
REQ-006 The block SHALL have port valid, output, 1 bit: high while the block is tracking (state TRACK).
REQ-007 The block SHALL have port dir, output, 1 bit: last observed step direction (1 = up, 0 = down).
REQ-008 The block SHALL have port step, output, 1 bit: one-cycle pulse per legal count change.
REQ-009 The block SHALL have port wrap_up, output, 1 bit: one-cycle pulse on a 3->0 transition.
REQ-010 The block SHALL have port wrap_dn, output, 1 bit: one-cycle pulse on a 0->3 transition.
REQ-011 The block SHALL have port laps, output, LAP_W bits: two's-complement net wrap count.
REQ-012 The block SHALL have port err, output, 1 bit: sticky illegal-transition flag.

Function
REQ-013 The block SHALL register q_in every cycle into q_prev; all outputs SHALL be registered.
REQ-014 The block SHALL implement states INIT, TRACK and FAULT.
REQ-015 In INIT, the block SHALL load q_prev, assert no pulses and move to TRACK on the next edge.
REQ-016 In TRACK, the block SHALL compute delta = (q_in - q_prev) mod 4 each cycle.
REQ-017 For delta 0, the block SHALL assert no pulse and hold dir.
REQ-018 For delta 1, the block SHALL pulse step and set dir=1.
REQ-019 For delta 3, the block SHALL pulse step and set dir=0.
REQ-020 For delta 2, the block SHALL move to FAULT, set err=1 and assert no step or wrap pulse.
REQ-021 Latency SHALL be one clock from the edge that samples a new q_in to the step/wrap/dir/laps/err update.
REQ-022 wrap_up SHALL coincide with step only when q_prev=3 and q_in=0.
REQ-023 wrap_dn SHALL coincide with step only when q_prev=0 and q_in=3.
REQ-024 On wrap_up, laps SHALL increment; on wrap_dn, laps SHALL decrement.
REQ-025 laps SHALL saturate at +(2^(LAP_W-1))-1 and -(2^(LAP_W-1)) with no wrap-around.
REQ-026 In FAULT, err SHALL remain 1, laps SHALL be frozen, step/wrap pulses SHALL be 0, valid SHALL be 0 and dir SHALL hold.
REQ-027 clr, in any state, SHALL set laps=0, err=0 and state=INIT at the next edge, and SHALL take priority over any transition sampled in the same cycle (no pulse, no laps update).
REQ-028 Pulses SHALL never be asserted for two consecutive cycles unless q_in legally changes on consecutive cycles.

Reset
REQ-029 While reset=0, the block SHALL hold state=INIT, q_prev=0, valid=0, dir=0, step=0, wrap_up=0, wrap_dn=0, laps=0 and err=0, asynchronously and independent of clk.
REQ-030 Deassertion of reset SHALL be synchronised internally (two-stage) so that state leaves INIT only on a clean edge.
REQ-031 Reset asserted mid-operation, including in FAULT, SHALL clear all outputs immediately, and tracking SHALL restart from INIT.

Verification
REQ-032 The bench SHALL cover: q_in counts up 0,1,2,3,0,1 after reset release -> step each cycle after INIT, dir=1, one wrap_up, laps=1.
REQ-033 The bench SHALL cover: q_in counts down 1,0,3,2,1,0,3 -> dir=0, two wrap_dn pulses, laps=-2 (0xFE for LAP_W=8).
REQ-034 The bench SHALL cover: q_in jumps 1->3 in TRACK -> err=1 one cycle later, valid=0, and later changes produce no step and leave laps frozen; clr -> err=0, INIT, then TRACK.
REQ-035 The bench SHALL cover: 130 up-laps with LAP_W=8 -> laps saturates at 127 (0x7F) and stays there; then 2 down-laps -> 125.
REQ-036 The bench SHALL cover: clr asserted in the same cycle as a 3->0 transition -> no wrap_up, laps=0, state INIT.
REQ-037 The bench SHALL cover: reset pulled low between clock edges during counting -> all outputs 0 before the next edge; after release, the first q_in is absorbed in INIT with no pulse.
